scoreboard_reg_file: RTL and testbench

Parametrised register file for the 4-bit CPU datapath and its wider derivatives: one synchronous write port, two asynchronous read ports (A/B operands). Adds a per-register scoreboard, with one busy bit per register set when an instruction reserves its destination and cleared when the result is written back, so issue logic can stall on RAW hazards. Sits between decode (reserve, read addresses) and writeback (load, addrD, data).

---
 rtl/scoreboard_reg_file.sv | 130 +++++++++++++
 tb/tb_scoreboard_reg_file.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_reg_file.sv
// Register file with per-register busy scoreboard for RAW hazard stalls.
// Ports: clk, clr (sync reset); write data/load/addrD; reads addrA/addrB -> a/b;
//   reserve rsv/rsv_addr; busy_a/busy_b, rsv_conflict, busy_cnt.
// Optional macro SCOREBOARD_BYPASS_EN: write-to-read forwarding.
module scoreboard_reg_file #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic [AW-1:0]    addrD,
  input  logic [AW-1:0]    addrA,
  input  logic [AW-1:0]    addrB,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic             rsv,
  input  logic [AW-1:0]    rsv_addr,
  output logic             busy_a,
  output logic             busy_b,
  output logic             rsv_conflict,
  output logic [AW:0]      busy_cnt
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;

  logic             wr_ok, rs_ok;
  logic             wbusy, rbusy;
  logic             inc, dec;
  logic [WIDTH-1:0] a_st, b_st;
  logic             ba_st, bb_st;

  // Out-of-range and hardwired-zero addresses never touch state.
  function automatic logic addr_ok(input logic [AW-1:0] ad);
    return (32'(ad) < DEPTH_U) && !((ZERO_REG != 0) && (ad == '0));
  endfunction

  // Address decode by comparison keeps reads of addresses >= DEPTH at 0.
  always_comb begin
    a_st  = '0;
    b_st  = '0;
    ba_st = 1'b0;
    bb_st = 1'b0;
    wbusy = 1'b0;
    rbusy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addrA == AW'(i)) begin
        a_st  = regs_q[i];
        ba_st = busy_q[i];
      end
      if (addrB == AW'(i)) begin
        b_st  = regs_q[i];
        bb_st = busy_q[i];
      end
      if (addrD == AW'(i))
        wbusy = busy_q[i];
      if (rsv_addr == AW'(i))
        rbusy = busy_q[i];
    end
  end

  always_comb begin
    wr_ok  = load && addr_ok(addrD);
    rs_ok  = rsv && addr_ok(rsv_addr);
    regs_d = regs_q;
    busy_d = busy_q;
    // Write clears busy first; a same-address reserve belongs to a newer
    // instruction and wins.
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_ok && (addrD == AW'(i))) begin
        regs_d[i] = data;
        busy_d[i] = 1'b0;
      end
      if (rs_ok && (rsv_addr == AW'(i)))
        busy_d[i] = 1'b1;
    end
    inc = rs_ok && !rbusy;
    dec = wr_ok && wbusy && !(rs_ok && (rsv_addr == addrD));
    cnt_d = cnt_q;
    if (inc && !dec)
      cnt_d = cnt_q + 1'b1;
    else if (dec && !inc)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++)
        regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        regs_q[i] <= regs_d[i];
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rsv_conflict = rs_ok && rbusy;
  assign busy_cnt     = cnt_q;

`ifdef SCOREBOARD_BYPASS_EN
  logic byp_a, byp_b;

  always_comb begin
    byp_a  = wr_ok && (addrD == addrA);
    byp_b  = wr_ok && (addrD == addrB);
    a      = byp_a ? data : a_st;
    b      = byp_b ? data : b_st;
    // A forwarded result retires the reservation unless it is re-reserved.
    busy_a = ba_st && !(byp_a && !(rs_ok && (rsv_addr == addrA)));
    busy_b = bb_st && !(byp_b && !(rs_ok && (rsv_addr == addrB)));
  end
`else
  assign a      = a_st;
  assign b      = b_st;
  assign busy_a = ba_st;
  assign busy_b = bb_st;
`endif

endmodule

// File: tb/tb_scoreboard_reg_file.sv
// Self-checking bench for scoreboard_reg_file.
// Two instances: default geometry, and DEPTH=6 with ZERO_REG=1.
module tb_scoreboard_reg_file;

  typedef enum int {K_A, K_B, K_BA, K_BB, K_CF, K_CNT} kind_e;
  typedef struct {
    int          d;
    kind_e       k;
    logic [31:0] v;
    string       nm;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   errs   = 0;
  int   checks = 0;

  logic       clk = 0;
  logic       clr, load, rsv;
  logic [3:0] data;
  logic [2:0] addrD, addrA, addrB, rsv_addr;
  logic [3:0] a0, b0;
  logic       ba0, bb0, cf0;
  logic [3:0] cnt0;

  logic       z_load, z_rsv;
  logic [3:0] z_data;
  logic [2:0] z_addrD, z_addrA, z_addrB, z_rsv_addr;
  logic [3:0] za, zb;
  logic       zba, zbb, zcf;
  logic [3:0] zcnt;

  logic [3:0] m_reg [8];
  logic       m_busy [8];

  always #5 clk = ~clk;

  scoreboard_reg_file #(.WIDTH(4), .DEPTH(8), .AW(3), .ZERO_REG(0)) dut0 (
    .clk(clk), .clr(clr), .data(data), .load(load), .addrD(addrD),
    .addrA(addrA), .addrB(addrB), .a(a0), .b(b0), .rsv(rsv),
    .rsv_addr(rsv_addr), .busy_a(ba0), .busy_b(bb0),
    .rsv_conflict(cf0), .busy_cnt(cnt0)
  );

  scoreboard_reg_file #(.WIDTH(4), .DEPTH(6), .AW(3), .ZERO_REG(1)) dut1 (
    .clk(clk), .clr(clr), .data(z_data), .load(z_load), .addrD(z_addrD),
    .addrA(z_addrA), .addrB(z_addrB), .a(za), .b(zb), .rsv(z_rsv),
    .rsv_addr(z_rsv_addr), .busy_a(zba), .busy_b(zbb),
    .rsv_conflict(zcf), .busy_cnt(zcnt)
  );

  function automatic logic [31:0] obs(int d, kind_e k);
    case (k)
      K_A:   return d ? 32'(za)   : 32'(a0);
      K_B:   return d ? 32'(zb)   : 32'(b0);
      K_BA:  return d ? 32'(zba)  : 32'(ba0);
      K_BB:  return d ? 32'(zbb)  : 32'(bb0);
      K_CF:  return d ? 32'(zcf)  : 32'(cf0);
      default: return d ? 32'(zcnt) : 32'(cnt0);
    endcase
  endfunction

  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic expect_v(int d, kind_e k, int v, string nm);
    exp_t x;
    x.d = d; x.k = k; x.v = 32'(v); x.nm = nm;
    q.push_back(x);
  endtask

  task automatic idle();
    clr = 0; load = 0; rsv = 0;
    z_load = 0; z_rsv = 0;
  endtask

  // Reference model for dut0 follows the behavioural rules; busy count
  // is derived as a popcount, not as a counter.
  task automatic tick();
    if (clr) begin
      for (int i = 0; i < 8; i++) begin
        m_reg[i] = 0; m_busy[i] = 0;
      end
    end else begin
      if (load) begin
        m_reg[addrD] = data; m_busy[addrD] = 0;
      end
      if (rsv) m_busy[rsv_addr] = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); clr = 1; data = 0; addrD = 0; addrA = 0; addrB = 0; rsv_addr = 0;
    z_data = 0; z_addrD = 0; z_addrA = 0; z_addrB = 0; z_rsv_addr = 0;
    tick();
    idle(); load = 1; addrD = 3; data = 4'hA;
    tick();
    idle(); clr = 1;
    tick();
    idle(); addrA = 3; addrB = 3;
    #1;
    expect_v(0, K_A, 0, "rst_a");
    expect_v(0, K_B, 0, "rst_b");
    expect_v(0, K_BA, 0, "rst_busy_a");
    expect_v(0, K_BB, 0, "rst_busy_b");
    expect_v(0, K_CF, 0, "rst_conflict");
    expect_v(0, K_CNT, 0, "rst_cnt");
    expect_v(1, K_CNT, 0, "rst_cnt_z");
    expect_v(1, K_BA, 0, "rst_busy_a_z");
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.d, e.k) !== e.v) begin
        errs++;
        $display("FAIL %s: got %0d expected %0d", e.nm, obs(e.d, e.k), e.v);
      end
    end
  endtask

  task automatic test_reserve_write();
    idle(); rsv = 1; rsv_addr = 5; addrA = 5;
    tick();
    idle();
    expect_v(0, K_BA, 1, "rsv_busy_a");
    expect_v(0, K_CNT, 1, "rsv_cnt");
    #1;
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.d, e.k) !== e.v) begin
        errs++;
        $display("FAIL %s: got %0d expected %0d", e.nm, obs(e.d, e.k), e.v);
      end
    end
    load = 1; addrD = 5; data = 4'h7;
    expect_v(0, K_A, 7, "wr_a");
    expect_v(0, K_BA, 0, "wr_busy_a");
    expect_v(0, K_CNT, 0, "wr_cnt");
    tick();
    idle();
    #1;
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.d, e.k) !== e.v) begin
        errs++;
        $display("FAIL %s: got %0d expected %0d", e.nm, obs(e.d, e.k), e.v);
      end
    end
  endtask

  task automatic test_same_addr();
    idle(); rsv = 1; rsv_addr = 2;
    tick();
    idle(); rsv = 1; rsv_addr = 2; load = 1; addrD = 2; data = 4'hC; addrA = 2;
    expect_v(0, K_CF, 1, "same_conflict");
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.d, e.k) !== e.v) begin
        errs++;
        $display("FAIL %s: got %0d expected %0d", e.nm, obs(e.d, e.k), e.v);
      end
    end
    expect_v(0, K_A, 4'hC, "same_a");
    expect_v(0, K_BA, 1, "same_busy");
    expect_v(0, K_CNT, 1, "same_cnt");
    tick();
    idle();
    #1;
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.d, e.k) !== e.v) begin
        errs++;
        $display("FAIL %s: got %0d expected %0d", e.nm, obs(e.d, e.k), e.v);
      end
    end
    load = 1; addrD = 2; data = 4'h1;
    tick();
    idle();
  endtask

  task automatic test_bypass();
    idle(); load = 1; addrD = 6; data = 4'h3;
    tick();
    idle(); rsv = 1; rsv_addr = 6;
    tick();
    idle(); load = 1; addrD = 6; data = 4'h9; addrA = 6; addrB = 6;
`ifdef SCOREBOARD_BYPASS_EN
    expect_v(0, K_A, 9, "byp_a_now");
    expect_v(0, K_B, 9, "byp_b_now");
    expect_v(0, K_BA, 0, "byp_busy_a_now");
`else
    expect_v(0, K_A, 3, "byp_a_now");
    expect_v(0, K_B, 3, "byp_b_now");
    expect_v(0, K_BA, 1, "byp_busy_a_now");
`endif
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.d, e.k) !== e.v) begin
        errs++;
        $display("FAIL %s: got %0d expected %0d", e.nm, obs(e.d, e.k), e.v);
      end
    end
    expect_v(0, K_A, 9, "byp_a_next");
    expect_v(0, K_B, 9, "byp_b_next");
    expect_v(0, K_BB, 0, "byp_busy_b_next");
    expect_v(0, K_CNT, 0, "byp_cnt_next");
    tick();
    idle();
    #1;
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.d, e.k) !== e.v) begin
        errs++;
        $display("FAIL %s: got %0d expected %0d", e.nm, obs(e.d, e.k), e.v);
      end
    end
  endtask

  task automatic test_boundary();
    idle(); z_load = 1; z_addrD = 5; z_data = 4'h5;
    tick();
    idle(); z_load = 1; z_addrD = 7; z_data = 4'hF; z_rsv = 1; z_rsv_addr = 7;
    tick();
    idle(); z_load = 1; z_addrD = 6; z_data = 4'hE; z_rsv = 1; z_rsv_addr = 6;
    tick();
    idle(); z_load = 1; z_addrD = 0; z_data = 4'hF; z_rsv = 1; z_rsv_addr = 0;
    tick();
    idle(); z_addrA = 7; z_addrB = 5;
    #1;
    expect_v(1, K_A, 0, "bnd_rd7");
    expect_v(1, K_BA, 0, "bnd_busy7");
    expect_v(1, K_B, 5, "bnd_rd5");
    expect_v(1, K_CNT, 0, "bnd_cnt");
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.d, e.k) !== e.v) begin
        errs++;
        $display("FAIL %s: got %0d expected %0d", e.nm, obs(e.d, e.k), e.v);
      end
    end
    z_addrA = 6; z_addrB = 0;
    #1;
    expect_v(1, K_A, 0, "bnd_rd6");
    expect_v(1, K_B, 0, "bnd_rd0");
    expect_v(1, K_BB, 0, "bnd_busy0");
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.d, e.k) !== e.v) begin
        errs++;
        $display("FAIL %s: got %0d expected %0d", e.nm, obs(e.d, e.k), e.v);
      end
    end
    z_rsv = 1; z_rsv_addr = 5; z_addrB = 5;
    tick();
    idle();
    expect_v(1, K_BB, 1, "bnd_busy5");
    expect_v(1, K_CNT, 1, "bnd_cnt5");
    #1;
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.d, e.k) !== e.v) begin
        errs++;
        $display("FAIL %s: got %0d expected %0d", e.nm, obs(e.d, e.k), e.v);
      end
    end
  endtask

  task automatic test_clr_pending();
    idle(); rsv = 1; rsv_addr = 1;
    tick();
    idle(); rsv = 1; rsv_addr = 4;
    tick();
    idle();
    expect_v(0, K_CNT, 2, "pend_cnt2");
    #1;
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.d, e.k) !== e.v) begin
        errs++;
        $display("FAIL %s: got %0d expected %0d", e.nm, obs(e.d, e.k), e.v);
      end
    end
    clr = 1;
    expect_v(0, K_CNT, 0, "pend_clr_cnt");
    tick();
    idle();
    #1;
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.d, e.k) !== e.v) begin
        errs++;
        $display("FAIL %s: got %0d expected %0d", e.nm, obs(e.d, e.k), e.v);
      end
    end
    load = 1; addrD = 4; data = 4'h5; addrA = 4;
    expect_v(0, K_CNT, 0, "late_wr_cnt");
    expect_v(0, K_A, 5, "late_wr_a");
    expect_v(0, K_BA, 0, "late_wr_busy");
    tick();
    idle();
    #1;
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.d, e.k) !== e.v) begin
        errs++;
        $display("FAIL %s: got %0d expected %0d", e.nm, obs(e.d, e.k), e.v);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      idle();
      clr      = ($urandom_range(0, 31) == 0);
      load     = $urandom_range(0, 1);
      rsv      = $urandom_range(0, 1);
      addrD    = 3'($urandom_range(0, 7));
      rsv_addr = 3'($urandom_range(0, 7));
      data     = 4'($urandom_range(0, 15));
      expect_v(0, K_CF, int'(rsv && m_busy[rsv_addr]), "rnd_conflict");
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front(); checks++;
        if (obs(e.d, e.k) !== e.v) begin
          errs++;
          $display("FAIL %s: got %0d expected %0d", e.nm, obs(e.d, e.k), e.v);
        end
      end
      tick();
      idle();
      addrA = 3'($urandom_range(0, 7));
      addrB = 3'($urandom_range(0, 7));
      expect_v(0, K_A, int'(m_reg[addrA]), "rnd_a");
      expect_v(0, K_B, int'(m_reg[addrB]), "rnd_b");
      expect_v(0, K_BA, int'(m_busy[addrA]), "rnd_busy_a");
      expect_v(0, K_BB, int'(m_busy[addrB]), "rnd_busy_b");
      expect_v(0, K_CNT, m_cnt(), "rnd_cnt_popcount");
      #1;
      while (q.size() > 0) begin
        e = q.pop_front(); checks++;
        if (obs(e.d, e.k) !== e.v) begin
          errs++;
          $display("FAIL %s: got %0d expected %0d", e.nm, obs(e.d, e.k), e.v);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_reg[i] = 0; m_busy[i] = 0;
    end
    @(posedge clk); #1;
    test_reset();
    test_reserve_write();
    test_same_addr();
    test_bypass();
    test_boundary();
    test_clr_pending();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
